hippo_mem_port: RTL and testbench



---
 rtl/hippo_mem_port.sv | 129 ++++++++++++
 tb/tb_hippo_mem_port.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hippo_mem_port.sv
// rtl/hippo_mem_port.sv - flow-controlled valid/ready front-end for a single-port BRAM; optional write acks under HIPPO_MEM_PORT_WACK_EN
module hippo_mem_port #(
   parameter  int DATA_WIDTH   = 8,
   parameter  int DEPTH        = 1024,
   parameter  int READ_LATENCY = 1,
   parameter  int RSP_DEPTH    = 2,
   localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
`ifdef HIPPO_MEM_PORT_WACK_EN
   output logic                  rsp_is_wr_o,
`endif
   output logic                  busy_o
);

   localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
   localparam int SUM_W = CNT_W + 1;

   logic                    fire;
   logic                    track;
   logic                    push;
   logic                    pop;
   logic [READ_LATENCY-1:0] pipe_vld;
   logic [SUM_W-1:0]        inflight;
   logic [CNT_W-1:0]        fifo_count;
   logic [PTR_W-1:0]        wr_ptr;
   logic [PTR_W-1:0]        rd_ptr;
   logic [DATA_WIDTH-1:0]   fifo_data [RSP_DEPTH];
   logic [DATA_WIDTH-1:0]   push_data;

   assign fire        = req_valid_i & req_ready_o;
   assign mem_addr_o  = req_addr_i;
   assign mem_wdata_o = req_wdata_i;
   assign mem_we_o    = fire & req_we_i;

`ifdef HIPPO_MEM_PORT_WACK_EN
   // Every accepted op takes a response slot; a per-stage flag remembers which were writes.
   logic [READ_LATENCY-1:0] pipe_wr;
   logic                    fifo_wr [RSP_DEPTH];
   assign track     = fire;
   assign push_data = pipe_wr[READ_LATENCY-1] ? '0 : mem_rdata_i;

   // Write-flag pipe runs in lockstep with the valid pipe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_wr <= '0;
      end else begin
         pipe_wr[0] <= fire & req_we_i;
         for (int i = 1; i < READ_LATENCY; i++) pipe_wr[i] <= pipe_wr[i-1];
      end
   end

   // Write-flag storage alongside the data entries.
   always_ff @(posedge clk_i) begin
      if (push) fifo_wr[wr_ptr] <= pipe_wr[READ_LATENCY-1];
   end

   assign rsp_is_wr_o = rsp_valid_o & fifo_wr[rd_ptr];
`else
   assign track     = fire & ~req_we_i;
   assign push_data = mem_rdata_i;
`endif

   // Valid shift register covering the fixed BRAM read latency.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= track;
         for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   // Count tracked ops still inside the latency pipe.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + SUM_W'(pipe_vld[i]);
   end

   // Credit check uses only registered state, so rsp_ready_i never reaches req_ready_o.
   assign req_ready_o = (({1'b0, fifo_count} + inflight) < SUM_W'(RSP_DEPTH));

   assign push        = pipe_vld[READ_LATENCY-1];
   assign rsp_valid_o = (fifo_count != '0);
   assign pop         = rsp_valid_o & rsp_ready_i;
   assign rsp_rdata_o = fifo_data[rd_ptr];
   assign busy_o      = (|pipe_vld) | (fifo_count != '0);

   // Response data storage; data capture needs no reset.
   always_ff @(posedge clk_i) begin
      if (push) fifo_data[wr_ptr] <= push_data;
   end

   // FIFO pointers and occupancy; pointers wrap naturally since RSP_DEPTH is a power of two.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // The credit rule must make a push into a full FIFO impossible.
   assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && (fifo_count == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_hippo_mem_port.sv
// tb/tb_hippo_mem_port.sv - scoreboard bench for hippo_mem_port with a BRAM model and reference memory
`timescale 1ns/1ps
module tb_hippo_mem_port;

   localparam int DW    = 8;
   localparam int DEPTH = 1024;
   localparam int RL    = 1;
   localparam int RSPD  = 2;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_ready = 1'b0;
   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          busy;
`ifdef HIPPO_MEM_PORT_WACK_EN
   logic          rsp_is_wr;
`endif

   hippo_mem_port #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .READ_LATENCY(RL), .RSP_DEPTH(RSPD)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata),
`ifdef HIPPO_MEM_PORT_WACK_EN
      .rsp_is_wr_o(rsp_is_wr),
`endif
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Single-port BRAM model: read-first, fixed read latency RL.
   logic [DW-1:0] bram [DEPTH];
   logic [DW-1:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      rd_pipe[0] <= bram[mem_addr];
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RL-1];

   typedef struct {
      logic [DW-1:0] data;
      logic          is_wr;
      int            due;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] ref_mem [DEPTH];
   int            fired_cnt  = 0;
   int            popped_cnt = 0;
   int            checks     = 0;
   int            errors     = 0;
   logic          mon_en     = 1'b0;
   int            outstanding;
   logic          exp_ready;
   logic          exp_valid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   // Monitor: every accepted op not yet popped holds one credit; responses leave in request order.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         outstanding = fired_cnt - popped_cnt;
         exp_ready   = (outstanding < RSPD);
         check("req_ready", req_ready, exp_ready);
         check("busy", busy, outstanding != 0);
         check("mem_we", mem_we, req_valid & req_we & exp_ready);
         check("mem_addr", mem_addr, req_addr);
         exp_valid = (q.size() > 0) && (q[0].due <= cycle);
         check("rsp_valid", rsp_valid, exp_valid);
         if (rsp_valid && exp_valid) begin
            check("rsp_rdata", rsp_rdata, q[0].data);
`ifdef HIPPO_MEM_PORT_WACK_EN
            check("rsp_is_wr", rsp_is_wr, q[0].is_wr);
`endif
            if (rsp_ready) begin
               void'(q.pop_front());
               popped_cnt++;
            end
         end
      end
   end

   task automatic book(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int fc);
      exp_t e;
      e.due = fc + RL + 1;
      if (we) begin
         ref_mem[a] = d;
`ifdef HIPPO_MEM_PORT_WACK_EN
         e.data = '0;
         e.is_wr = 1'b1;
         q.push_back(e);
         fired_cnt++;
`endif
      end else begin
         e.data = ref_mem[a];
         e.is_wr = 1'b0;
         q.push_back(e);
         fired_cnt++;
      end
   endtask

   task automatic do_cycle(input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output logic fired);
      int fc;
      req_valid = v;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      fired = v && req_ready;
      fc = cycle;
      @(posedge clk);
      if (fired) book(we, a, d, fc);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic f;
      int   n;
      n = 0;
      do begin
         do_cycle(1'b1, we, a, d, f);
         n++;
      end while (!f && n < 40);
      if (!f) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: request addr 0x%0h not accepted, required within 40 cycles", a);
      end
   endtask

   task automatic idle(input int n);
      logic f;
      repeat (n) do_cycle(1'b0, 1'b0, '0, '0, f);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 200) begin
         idle(1);
         n++;
      end
      check("drain_empty", q.size(), 0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      req_valid = 1'b0;
      repeat (n) @(posedge clk);
      q.delete();
      fired_cnt  = 0;
      popped_cnt = 0;
      #1;
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_req_ready"}, req_ready, 1'b1);
      check({tag, "_mem_we"}, mem_we, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic f;
      for (int i = 0; i < DEPTH; i++) begin
         bram[i]    = '0;
         ref_mem[i] = '0;
      end
      @(posedge clk);
      #1;

      // Reset then idle.
      do_reset(2);
      mon_en = 1'b1;
      check_idle("reset");
      idle(2);

      // Write then read the same address on the next cycle.
      rsp_ready = 1'b1;
      issue(1'b1, AW'(5), 8'hA5);
      issue(1'b0, AW'(5), '0);
      drain();

      // Streaming reads over freshly written words.
      for (int a = 0; a < 16; a++) issue(1'b1, AW'(a), DW'($urandom));
      for (int a = 0; a < 16; a++) issue(1'b0, AW'(a), '0);
      drain();

      // Backpressure: two reads fill the credits, the third waits.
      rsp_ready = 1'b0;
      issue(1'b0, AW'(1), '0);
      issue(1'b0, AW'(2), '0);
      repeat (3) begin
         do_cycle(1'b1, 1'b0, AW'(3), '0, f);
         check("bp_stall", f, 1'b0);
      end
      rsp_ready = 1'b1;
      issue(1'b0, AW'(3), '0);
      drain();

      // Reset with a read in flight: nothing may come out afterwards.
      issue(1'b0, AW'(5), '0);
      do_reset(2);
      check_idle("midrst");
      idle(6);

`ifdef HIPPO_MEM_PORT_WACK_EN
      // Write ack ordered ahead of the following read.
      issue(1'b1, AW'(16), 8'h3C);
      issue(1'b0, AW'(16), '0);
      drain();
`endif

      // Randomized mix with random consumer backpressure.
      for (int i = 0; i < 400; i++) begin
         rsp_ready = ($urandom_range(3) != 0);
         do_cycle($urandom_range(2) != 0, $urandom_range(1) == 1,
                  AW'($urandom_range(15)), DW'($urandom), f);
      end
      rsp_ready = 1'b1;
      drain();
      idle(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
